// File: rtl/alu_8_sequencer.sv
// -----------------------------------------------------------------------------
// alu_8_sequencer
//
// Request-side controller for the combinational 8-bit ALU. Accepts one
// operation at a time, drives the ALU from registered operands, captures the
// ALU result, computes Z80-style F-register flags and returns result + flags.
// Owns the persistent flag register.
//
// Parameters:
//   EXEC_CYCLES : cycles the ALU inputs are held stable before capture (1..15)
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_op, req_a, req_b     : opcode (0..12 legal) and operands
//   alu_opcode, alu_a, alu_b : registered drive into the ALU
//   alu_out                  : ALU result
//   rsp_valid/rsp_ready      : response handshake
//   rsp_result, rsp_flags    : result and F register (S Z 0 H 0 P/V N C)
//   rsp_err                  : illegal opcode marker for this response
// -----------------------------------------------------------------------------
module alu_8_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [7:0] rsp_flags,
    output logic       rsp_err
);

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CP  = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SLA = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;
    localparam logic [3:0] OP_INC = 4'd11;
    localparam logic [3:0] OP_DEC = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       issued_q, issued_d;
    logic [3:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [3:0] alu_opcode_q, alu_opcode_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] res_q, res_d;
    logic [7:0] flag_q, flag_d;
    logic       err_q, err_d;

    // Even parity: 1 when the value has an even number of set bits.
    function automatic logic even_parity(input logic [7:0] v);
        return ~(^v);
    endfunction

    // F register for a legal op, from latched operands, ALU result and old carry.
    function automatic logic [7:0] calc_flags(
        input logic [3:0] op,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] res,
        input logic       c_old
    );
        logic [8:0] sum9;
        logic [4:0] nib5;
        logic       s, z, h, pv, n, c;
        sum9 = {1'b0, a} + {1'b0, b};
        nib5 = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        s    = res[7];
        z    = (res == 8'h00);
        h    = 1'b0;
        pv   = 1'b0;
        n    = 1'b0;
        c    = c_old;
        case (op)
            OP_ADD: begin
                c  = sum9[8];
                h  = nib5[4];
                pv = (a[7] == b[7]) && (res[7] != a[7]);
            end
            OP_SUB, OP_CP: begin
                c  = (a < b);
                h  = (a[3:0] < b[3:0]);
                pv = (a[7] != b[7]) && (res[7] != a[7]);
                n  = 1'b1;
            end
            OP_AND: begin
                h  = 1'b1;
                c  = 1'b0;
                pv = even_parity(res);
            end
            OP_OR, OP_XOR: begin
                c  = 1'b0;
                pv = even_parity(res);
            end
            OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROR: begin
                // Carry is deliberately left as it was in the flag register.
                pv = even_parity(res);
            end
            OP_INC: begin
                h  = (a[3:0] == 4'hF);
                pv = (a == 8'h7F);
            end
            OP_DEC: begin
                h  = (a[3:0] == 4'h0);
                pv = (a == 8'h80);
                n  = 1'b1;
            end
            default: begin
                pv = 1'b0;
            end
        endcase
        return {s, z, 1'b0, h, 1'b0, pv, n, c};
    endfunction

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        issued_d     = issued_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        res_d        = res_q;
        flag_d       = flag_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d         = req_op;
                    a_d          = req_a;
                    b_d          = req_b;
                    // CP is a subtraction whose result is discarded.
                    alu_opcode_d = (req_op == OP_CP) ? OP_SUB : req_op;
                    alu_a_d      = req_a;
                    alu_b_d      = req_b;
                    cnt_d        = CNT_LOAD;
                    issued_d     = 1'b0;
                    state_d      = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // The first EXEC cycle is the operand-issue cycle; the
                // countdown of EXEC_CYCLES stable cycles starts after it.
                if (!issued_q) begin
                    issued_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    if (op_q <= OP_DEC) begin
                        res_d  = (op_q == OP_CP) ? a_q : alu_out;
                        flag_d = calc_flags(op_q, a_q, b_q, alu_out, flag_q[0]);
                        err_d  = 1'b0;
                    end else begin
                        res_d = 8'h00;
                        err_d = 1'b1;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            issued_q     <= 1'b0;
            op_q         <= 4'd0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            alu_opcode_q <= 4'd0;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            rsp_valid_q  <= 1'b0;
            res_q        <= 8'h00;
            flag_q       <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            issued_q     <= issued_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            res_q        <= res_d;
            flag_q       <= flag_d;
            err_q        <= err_d;
        end
    end

    // Ready is low throughout reset, so it is decoded from state and rst.
    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flag_q;
    assign rsp_err    = err_q;

endmodule
